// File: rtl/vga_timing_pkg.sv
// Shared 800x600 @ 72 Hz timing constants and the sync-decoder FSM state
// encoding. The same constants drive the `vga` timing generator.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE   = 800;
  localparam int VGA_H_FRONT     = 56;
  localparam int VGA_H_SYNC      = 120;
  localparam int VGA_H_WHOLE     = 1040;
  localparam int VGA_V_VISIBLE   = 600;
  localparam int VGA_V_FRONT     = 37;
  localparam int VGA_V_SYNC      = 6;
  localparam int VGA_V_WHOLE     = 666;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    H_ACQ  = 2'd1,
    V_ACQ  = 2'd2,
    LOCKED = 2'd3
  } dec_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync line and flags its falling edge.
// Both registers reset high so that an idle (high) line never looks like an edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sync_i,
  output logic fall_o
);

  logic s_q;
  logic s_prev_q;

  // Capture the sync line and keep its previous sampled value.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments let s_prev_q take the old s_q, giving a two-stage shift.
    if (reset_i) begin
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      s_q      <= sync_i;
      s_prev_q <= s_q;
    end
  end

  assign fall_o = ~s_q & s_prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receiving end of the VGA link: regenerates x/y/display from the incoming
// sync stream, tracks timing lock and reports sync mismatches.
// Optional build macro VGA_DECODE_STATS_EN adds a saturating sync-error counter;
// without it err_count is tied to zero.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_WHOLE     = VGA_H_WHOLE,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_WHOLE     = VGA_V_WHOLE,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       display,
  output logic       pixel_out,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);

  // Counter load values and expected edge positions. An h edge is seen one
  // clock after the generator drops h_sync, so the counter sits one short of
  // the sync start when it matches and reloads to the sync start itself.
  localparam logic [10:0] H_LOAD  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_MATCH = 11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] H_LAST  = 11'(H_WHOLE - 1);
  localparam logic [10:0] H_VIS_W = 11'(H_VISIBLE);
  localparam logic [9:0]  V_LOAD  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_MATCH = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_WHOLE - 1);
  localparam logic [9:0]  V_VIS_W = 10'(V_VISIBLE);
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_FRAMES);

  // A parameter set whose sync pulse overruns the line/frame, or whose lock
  // depth does not fit the match counter, cannot describe a real stream; the
  // decoder then never declares lock instead of reporting bogus coordinates.
  localparam bit TIMING_OK = (H_VISIBLE + H_FRONT + H_SYNC < H_WHOLE) &&
                             (V_VISIBLE + V_FRONT + V_SYNC < V_WHOLE) &&
                             (LOCK_FRAMES >= 1) && (LOCK_FRAMES <= 15);

  logic        h_fall;
  logic        v_fall;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_wrap;
  logic        h_pos;
  logic        v_pos;
  logic        mismatch;
  dec_state_e  state_q, state_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic        sync_err_q;
  logic [1:0]  pix_q;

  sync_edge_detect u_h_edge (
    .clk_i   (clk_50mhz),
    .reset_i (reset),
    .sync_i  (h_sync_in),
    .fall_o  (h_fall)
  );

  sync_edge_detect u_v_edge (
    .clk_i   (clk_50mhz),
    .reset_i (reset),
    .sync_i  (v_sync_in),
    .fall_o  (v_fall)
  );

  // Free-running position counters, re-phased by every detected sync edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_fall) begin
      h_cnt_d = H_LOAD;
    end
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    // The v-edge load wins over a same-cycle wrap increment.
    if (v_fall) begin
      v_cnt_d = V_LOAD;
    end
  end

  // Compare detected edges against where the counters say they belong.
  always_comb begin
    h_pos    = (h_cnt_q == H_MATCH);
    v_pos    = h_wrap && (v_cnt_q == V_MATCH);
    mismatch = ((state_q == V_ACQ) || (state_q == LOCKED)) &&
               ((h_fall != h_pos) || (v_fall != v_pos));
  end

  // State, counters and pipeline registers.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      match_cnt_q <= 4'd0;
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 10'd0;
      sync_err_q  <= 1'b0;
      pix_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      sync_err_q  <= mismatch;
      pix_q       <= {pix_q[0], rgb_in};
    end
  end

  // Lock acquisition: first h edge, first v edge, then LOCK_FRAMES matching v edges.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (h_fall) state_d = H_ACQ;
      end
      H_ACQ: begin
        if (v_fall) begin
          state_d     = V_ACQ;
          match_cnt_d = 4'd0;
        end
      end
      V_ACQ: begin
        if (mismatch) begin
          state_d     = H_ACQ;
          match_cnt_d = 4'd0;
        end else if (v_fall) begin
          match_cnt_d = match_cnt_q + 4'd1;
          if (TIMING_OK && (match_cnt_d == LOCK_TARGET)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d     = H_ACQ;
          match_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        match_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs decoded from registered state and counters.
  always_comb begin
    locked      = (state_q == LOCKED);
    display     = locked && (h_cnt_q < H_VIS_W) && (v_cnt_q < V_VIS_W);
    frame_start = locked && (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    x           = h_cnt_q[9:0];
    y           = v_cnt_q;
    pixel_out   = pix_q[1];
    sync_err    = sync_err_q;
  end

`ifdef VGA_DECODE_STATS_EN
  logic [7:0] err_count_q;

  // Saturating count of sync_err pulses; cleared only by reset.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (sync_err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced timing set so whole
// frames fit in a short run. A small generator drives the sync stream;
// overrides let the stimulus delay, suppress or fabricate sync edges.
module tb_vga_sync_decoder;

  localparam int HV = 8, HF = 2, HS = 5, HW = 20;
  localparam int VV = 6, VF = 1, VS = 2, VW = 10;
  localparam int LF = 2;
  localparam int FRAME = HW * VW;
`ifdef VGA_DECODE_STATS_EN
  localparam int EXP_ERR_100 = 100;
  localparam int EXP_ERR_300 = 255;
`else
  localparam int EXP_ERR_100 = 0;
  localparam int EXP_ERR_300 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gen_rst = 1'b1;
  logic h_ovr_en = 1'b0, h_ovr = 1'b1;
  logic v_ovr_en = 1'b0, v_ovr = 1'b1;
  logic [9:0] gx = '0, gy = '0;
  logic [9:0] gx_d1 = '0, gx_d2 = '0, gy_d1 = '0, gy_d2 = '0;
  logic rgb_d1 = 1'b0, rgb_d2 = 1'b0, disp_d1 = 1'b0, disp_d2 = 1'b0;
  logic gen_h, gen_v, gen_rgb, gen_disp;
  logic h_sync_in, v_sync_in;
  logic [9:0] x, y;
  logic display, pixel_out, locked, frame_start, sync_err;
  logic [7:0] err_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_pulses = 0;
  int gen_vedges = 0;

  always #5 clk = ~clk;

  assign gen_h    = !((gx >= 10'(HV + HF)) && (gx < 10'(HV + HF + HS)));
  assign gen_v    = !((gy >= 10'(VV + VF)) && (gy < 10'(VV + VF + VS)));
  assign gen_rgb  = gx[1] ^ gy[0];
  assign gen_disp = (gx < 10'(HV)) && (gy < 10'(VV));
  assign h_sync_in = h_ovr_en ? h_ovr : gen_h;
  assign v_sync_in = v_ovr_en ? v_ovr : gen_v;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_WHOLE(HW),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_WHOLE(VW),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk_50mhz   (clk),
    .reset       (reset),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .rgb_in      (gen_rgb),
    .x           (x),
    .y           (y),
    .display     (display),
    .pixel_out   (pixel_out),
    .locked      (locked),
    .frame_start (frame_start),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  // Reference timing generator plus its 2-clock delayed view.
  always @(posedge clk) begin
    if (gen_rst) begin
      gx <= '0;
      gy <= '0;
    end else if (gx == 10'(HW - 1)) begin
      gx <= '0;
      gy <= (gy == 10'(VW - 1)) ? 10'd0 : gy + 10'd1;
    end else begin
      gx <= gx + 10'd1;
    end
    gx_d1   <= gx;      gx_d2   <= gx_d1;
    gy_d1   <= gy;      gy_d2   <= gy_d1;
    rgb_d1  <= gen_rgb; rgb_d2  <= rgb_d1;
    disp_d1 <= gen_disp; disp_d2 <= disp_d1;
    cyc <= cyc + 1;
  end

  // Event counters: sync_err pulses and generator v_sync falling edges.
  always @(negedge clk) begin
    if (sync_err === 1'b1) err_pulses <= err_pulses + 1;
    if (!gen_rst && gx == 10'd0 && gy == 10'(VV + VF)) gen_vedges <= gen_vedges + 1;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_lock(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (locked === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gen(input logic [9:0] px, input logic [9:0] py, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (gx == px && gy == py) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_display"}, display, 0);
    check({tag, "_pixel"}, pixel_out, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_sync_err"}, sync_err, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin : stim
    bit ok;
    int v0, p0, n, xs, fs0, fs1;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset   = 1'b0;
    gen_rst = 1'b0;

    // First acquisition: lock one clock after the 3rd v edge is detected.
    v0 = gen_vedges;
    wait_lock(6 * FRAME, ok);
    check("lock1_ok", ok, 1);
    check("lock1_vedges", gen_vedges - v0, 3);
    check("lock1_gx", gx, 2);
    check("lock1_gy", gy, VV + VF);

    // Two frames of tracking: 2-clock lag, one frame_start per frame, no errors.
    n = 0; fs0 = 0; fs1 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      check("trk_x", x, gx_d2);
      check("trk_y", y, gy_d2);
      check("trk_display", display, disp_d2);
      check("trk_pixel", pixel_out, rgb_d2);
      check("trk_sync_err", sync_err, 0);
      check("trk_frame_start", frame_start, (gx_d2 == 0 && gy_d2 == 0));
      if (frame_start === 1'b1) begin
        if (n == 0) fs0 = cyc;
        else if (n == 1) fs1 = cyc;
        n++;
      end
      @(negedge clk);
    end
    check("fs_count", n, 2);
    check("fs_period", fs1 - fs0, FRAME);

    // One h_sync falling edge delayed by 3 clocks.
    wait_gen(10'(HV + HF - 1), 10'd2, ok);
    check("late_pos_found", ok, 1);
    h_ovr = 1'b1; h_ovr_en = 1'b1;
    n = 0; xs = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sync_err === 1'b1) begin
        n++;
        if (xs < 0) xs = x;
      end
      if (i == 3) h_ovr_en = 1'b0;
    end
    check("late_err_pulses", n, 1);
    check("late_err_x", xs, HV + HF);
    check("late_locked", locked, 0);
    v0 = gen_vedges;
    wait_lock(5 * FRAME, ok);
    check("late_relock_ok", ok, 1);
    check("late_relock_vedges", gen_vedges - v0, 3);

    // h_sync held high for one whole line: missing-edge error.
    wait_gen(10'(HV + HF - 1), 10'd2, ok);
    check("miss_pos_found", ok, 1);
    h_ovr = 1'b1; h_ovr_en = 1'b1;
    n = 0; xs = -1;
    for (int i = 0; i < HW; i++) begin
      @(negedge clk);
      if (sync_err === 1'b1) begin
        n++;
        if (xs < 0) xs = x;
      end
    end
    h_ovr_en = 1'b0;
    check("miss_err_pulses", n, 1);
    check("miss_err_x", xs, HV + HF);
    check("miss_locked", locked, 0);
    v0 = gen_vedges;
    wait_lock(5 * FRAME, ok);
    check("miss_relock_ok", ok, 1);
    check("miss_relock_vedges", gen_vedges - v0, 3);

    // Reset mid-frame (decoder only, generator keeps running).
    wait_gen(10'd7, 10'd3, ok);
    check("mid_pos_found", ok, 1);
    check("mid_pre_y", y, 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    v0 = gen_vedges;
    wait_lock(5 * FRAME, ok);
    check("mid_relock_ok", ok, 1);
    check("mid_relock_vedges", gen_vedges - v0, 3);

    // Error storm: fabricated v edges alternate error / re-enter V_ACQ.
    v_ovr = 1'b1; v_ovr_en = 1'b1;
    repeat (2) @(negedge clk);
    p0 = err_pulses;
    for (int i = 0; i < 100; i++) begin
      v_ovr = 1'b0; @(negedge clk);
      v_ovr = 1'b1; @(negedge clk);
      v_ovr = 1'b0; @(negedge clk);
      v_ovr = 1'b1; @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("storm100_pulses", err_pulses - p0, 100);
    check("storm100_err_count", err_count, EXP_ERR_100);
    for (int i = 0; i < 200; i++) begin
      v_ovr = 1'b0; @(negedge clk);
      v_ovr = 1'b1; @(negedge clk);
      v_ovr = 1'b0; @(negedge clk);
      v_ovr = 1'b1; @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("storm300_pulses", err_pulses - p0, 300);
    check("storm300_err_count", err_count, EXP_ERR_300);
    check("storm_locked", locked, 0);
    v_ovr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers pixel coordinates and lock status from an incoming 800x600 @ 72 Hz VGA sync stream. Its input is exactly what the `vga` timing generator produces: active-low `h_sync`, `v_sync` and a 1-bit pixel. Its outputs are regenerated `x`, `y`, `display` and an aligned pixel. It sits at the receiving end of the VGA link. Uses: frame capture, pixel-accurate self-check of the `metaballs` renderer, and a loopback monitor on the demo board.

## Interface

Parameters:
- `H_VISIBLE`, 800, visible pixels per line
- `H_FRONT`, 56, horizontal front porch (clocks)
- `H_SYNC`, 120, horizontal sync width (clocks)
- `H_WHOLE`, 1040, clocks per line
- `V_VISIBLE`, 600, visible lines
- `V_FRONT`, 37, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_WHOLE`, 666, lines per frame
- `LOCK_FRAMES`, 2, consecutive matching vertical edges required for lock (1..15)

Ports:
- `clk_50mhz`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `h_sync_in`  in  1  active-low horizontal sync
- `v_sync_in`  in  1  active-low vertical sync
- `rgb_in`  in  1  pixel value
- `x`  out  10  recovered column (`h_cnt[9:0]`)
- `y`  out  10  recovered line (`v_cnt`)
- `display`  out  1  `locked && h_cnt < H_VISIBLE && v_cnt < V_VISIBLE`
- `pixel_out`  out  1  `rgb_in` delayed 2 clocks, aligned with `x`/`y`
- `locked`  out  1  timing lock acquired
- `frame_start`  out  1  one-cycle pulse when locked and at `x==0`, `y==0`
- `sync_err`  out  1  one-cycle pulse on any sync mismatch
- `err_count`  out  8  saturating error count (see Configuration)

## Operation

Input capture and edge detection:
- Each sync input is registered once (`s_h`, `s_v`), plus a previous-value register.
- Falling edge = `s==0 && s_prev==1`.

Horizontal counter `h_cnt` (11 bits):
- Increments each clock and wraps at `H_WHOLE-1` to 0.
- On an h edge it loads `H_VISIBLE+H_FRONT`.

Vertical counter `v_cnt` (10 bits):
- Increments on the `h_cnt` wrap and wraps at `V_WHOLE-1` to 0.
- On a v edge it loads `V_VISIBLE+V_FRONT`.
- A v-edge load has priority over a same-cycle wrap increment.

Expected edge positions:
- h match: h edge while `h_cnt == H_VISIBLE+H_FRONT-1`.
- v match: v edge while `h_cnt == H_WHOLE-1` and `v_cnt == V_VISIBLE+V_FRONT-1`.

Mismatch (only in states V_ACQ and LOCKED):
- An edge at any other position, or
- the expected position reached with no edge.
- Effect: `sync_err` pulses, `match_cnt` clears, FSM goes to H_ACQ; counters still reload on the edge.

FSM:
- IDLE: on the first h edge → H_ACQ.
- H_ACQ: on the first v edge → V_ACQ with `match_cnt=0`; h mismatches are ignored in this state.
- V_ACQ: on each v match `match_cnt++`; when it reaches `LOCK_FRAMES` → LOCKED.
- LOCKED: `locked=1`; any mismatch → H_ACQ.
- `locked` is registered and high only in LOCKED.

## Timing

- With a `vga` instance on the same clock, `x`, `y` and `pixel_out` lag the generator's `x`/`y` by exactly 2 clocks once locked.
- `display` also lags the generator's `display` by exactly 2 clocks once locked.
- Lock is acquired after the first h edge, then 1 + `LOCK_FRAMES` v edges.
- `locked` rises the clock after the final matching v edge is detected.
- `sync_err` is high on the clock after the offending condition.
- Reset values: `h_cnt=v_cnt=0`; `x=0`, `y=0`; `display=0`, `pixel_out=0`, `locked=0`, `frame_start=0`, `sync_err=0`, `err_count=0`; FSM IDLE; edge registers at 1 (idle high).
- Reset asserted mid-frame: all of the above are restored on the next edge and reacquisition starts from IDLE.

## Configuration

- Macro `VGA_DECODE_STATS_EN`.
- Defined: `err_count` increments on every `sync_err` pulse and saturates at 255. It clears only on `reset`.
- Undefined: `err_count` is tied to 0 and no counter logic is built.

## Structure

- Package `vga_timing_pkg` holds:
  - the 800x600 @ 72 timing constants, shared with `vga`;
  - the FSM state enum (IDLE, H_ACQ, V_ACQ, LOCKED).
- Sub-module `sync_edge_detect` contains the capture register, the previous register and the falling-edge output. It is instantiated twice, for h and v.

## Test plan

- Reset, then drive from a `vga` instance → `locked` rises after the 3rd v edge; afterwards `x`/`y` equal the generator's values delayed 2 clocks over a full frame; `sync_err` never pulses.
- Locked; check `frame_start` → exactly one pulse per frame (every 692,640 clocks), coincident with `x==0`, `y==0`.
- Locked; one h_sync falling edge is delayed by 3 clocks → `sync_err` pulses; `locked` drops and is regained after 3 further v edges.
- Locked; `h_sync_in` is held high for one whole line → missing-edge `sync_err` at `h_cnt==855`; `locked=0`.
- `reset` asserted at `y=300` → next clock all outputs are 0 and the FSM is IDLE; relock follows the first scenario.
- With `VGA_DECODE_STATS_EN`, inject 300 sync errors → `err_count` saturates at 255. Without the macro, `err_count` stays 0.
